// File: rtl/vending_txn_ctrl_pkg.sv
// Shared definitions for the vending transaction sequencer.
// Holds the coin and item tables, widths, the wait time and the state encoding.
// coin_value/item_price map a one-hot vector to its table value. A vector that
// is zero or multi-hot gives a meaningless result, so callers qualify it first.
package vending_txn_ctrl_pkg;

   localparam int kNumCoins   = 3;
   localparam int kNumItems   = 4;
   localparam int kTotalBits  = 30;
   localparam int kBalW       = kTotalBits + 1;
   localparam int kMaxBalance = 10000;
   localparam int kWaitTime   = 30;

   localparam logic [kBalW-1:0] kCoinValue [kNumCoins] = '{31'd100, 31'd500, 31'd1000};
   localparam logic [kBalW-1:0] kItemPrice [kNumItems] = '{31'd400, 31'd500, 31'd1000, 31'd2000};

   typedef enum logic [1:0] {
      kSIdle   = 2'd0,
      kSHold   = 2'd1,
      kSVend   = 2'd2,
      kSReturn = 2'd3
   } state_e;

   function automatic logic [kBalW-1:0] coin_value(input logic [kNumCoins-1:0] oh);
      logic [kBalW-1:0] v;
      v = '0;
      for (int i = 0; i < kNumCoins; i++)
         if (oh[i]) v = v | kCoinValue[i];
      return v;
   endfunction

   function automatic logic [kBalW-1:0] item_price(input logic [kNumItems-1:0] oh);
      logic [kBalW-1:0] v;
      v = '0;
      for (int i = 0; i < kNumItems; i++)
         if (oh[i]) v = v | kItemPrice[i];
      return v;
   endfunction

endpackage

// File: rtl/vending_txn_ctrl_change_pick.sv
// vm_change_pick: combinational change selector.
// Ports:
//   i_balance  in   current credit
//   o_coin     out  one-hot largest coin whose value <= i_balance (0 if none)
//   o_value    out  value of that coin (0 if none)
module vm_change_pick
   import vending_txn_ctrl_pkg::*;
(
   input  logic [kBalW-1:0]     i_balance,
   output logic [kNumCoins-1:0] o_coin,
   output logic [kBalW-1:0]     o_value
);

   // The coin table is ascending, so the last coin that fits is the largest.
   always_comb begin
      o_coin  = '0;
      o_value = '0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (i_balance >= kCoinValue[i]) begin
            o_coin    = '0;
            o_coin[i] = 1'b1;
            o_value   = kCoinValue[i];
         end
      end
   end

endmodule

// File: rtl/vending_txn_ctrl.sv
// vending_txn_ctrl: vending machine transaction sequencer.
// Adds up inserted coins, grants affordable purchases and pays change on timeout or cancel.
// Change is paid largest coin first.
// Optional feature macro: VM_TXN_CANCEL_EN. When it is defined, the i_trigger_return
// port exists and cancels a transaction from HOLD.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   i_input_coin      one-hot coin pulse
//   i_select_item     one-hot selection pulse
//   i_timeout         wait-timer expired level
//   i_trigger_return  cancel request (VM_TXN_CANCEL_EN only)
//   o_timeset         wait-timer reload pulse
//   o_available_item  items affordable with current balance
//   o_output_item     dispense pulse
//   o_return_coin     change / bounced-coin pulse
//   o_balance         current credit
//   o_busy            VEND or RETURN in progress
//
// state   | meaning
// IDLE    | balance zero, waiting for a coin
// HOLD    | credit held, waiting for coin/select/cancel/timeout
// VEND    | dispense pulse visible, one cycle
// RETURN  | paying change, one coin per cycle
module vending_txn_ctrl
   import vending_txn_ctrl_pkg::*;
#(
   parameter int NUM_COINS   = kNumCoins,
   parameter int NUM_ITEMS   = kNumItems,
   parameter int BAL_W       = kBalW,
   parameter int MAX_BALANCE = kMaxBalance
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_COINS-1:0] i_input_coin,
   input  logic [NUM_ITEMS-1:0] i_select_item,
   input  logic                 i_timeout,
`ifdef VM_TXN_CANCEL_EN
   input  logic                 i_trigger_return,
`endif
   output logic                 o_timeset,
   output logic [NUM_ITEMS-1:0] o_available_item,
   output logic [NUM_ITEMS-1:0] o_output_item,
   output logic [NUM_COINS-1:0] o_return_coin,
   output logic [BAL_W-1:0]     o_balance,
   output logic                 o_busy
);

   localparam logic [BAL_W-1:0] kMaxBal = BAL_W'(MAX_BALANCE);

   state_e               state_q, state_d;
   logic [BAL_W-1:0]     bal_q, bal_d;
   logic                 timeset_q, timeset_d;
   logic [NUM_ITEMS-1:0] avail_q, avail_d;
   logic [NUM_ITEMS-1:0] item_q, item_d;
   logic [NUM_COINS-1:0] ret_q, ret_d;
   logic                 busy_q, busy_d;

   logic                 cancel_req;
   logic                 coin_ok, sel_ok;
   logic [BAL_W-1:0]     coin_sum, sel_price;
   logic [NUM_COINS-1:0] pick_coin;
   logic [BAL_W-1:0]     pick_value;

`ifdef VM_TXN_CANCEL_EN
   assign cancel_req = i_trigger_return;
`else
   assign cancel_req = 1'b0;
`endif

   vm_change_pick u_change_pick (
      .i_balance (bal_q),
      .o_coin    (pick_coin),
      .o_value   (pick_value)
   );

   // Overflow cannot occur: balance <= 10000 and coins <= 1000 in a 31-bit sum.
   assign coin_ok   = $onehot(i_input_coin);
   assign coin_sum  = bal_q + coin_value(i_input_coin);
   assign sel_price = item_price(i_select_item);
   assign sel_ok    = $onehot(i_select_item) && (bal_q >= sel_price);

   always_comb begin
      state_d   = state_q;
      bal_d     = bal_q;
      timeset_d = 1'b0;
      item_d    = '0;
      ret_d     = '0;
      case (state_q)
         kSIdle: begin
            if (coin_ok) begin
               if (coin_sum <= kMaxBal) begin
                  bal_d     = coin_sum;
                  timeset_d = 1'b1;
                  state_d   = kSHold;
               end else begin
                  ret_d = i_input_coin;
               end
            end
         end
         kSHold: begin
            if (coin_ok) begin
               if (coin_sum <= kMaxBal) begin
                  bal_d     = coin_sum;
                  timeset_d = 1'b1;
               end else begin
                  ret_d = i_input_coin;
               end
            end else if (sel_ok) begin
               // Dispense is registered here so the pulse is visible during VEND.
               item_d    = i_select_item;
               bal_d     = bal_q - sel_price;
               timeset_d = 1'b1;
               state_d   = kSVend;
            end else if (cancel_req) begin
               state_d = kSReturn;
            end else if (i_timeout && !timeset_q) begin
               // While a reload is in flight, the timer still shows the old expiry.
               state_d = kSReturn;
            end
         end
         kSVend: begin
            state_d = (bal_q != '0) ? kSHold : kSIdle;
         end
         kSReturn: begin
            ret_d = pick_coin;
            bal_d = bal_q - pick_value;
            if (bal_d == '0) state_d = kSIdle;
         end
         default: state_d = kSIdle;
      endcase

      avail_d = '0;
      for (int i = 0; i < NUM_ITEMS; i++)
         avail_d[i] = (state_d != kSReturn) && (bal_d >= kItemPrice[i]);
      busy_d = (state_d == kSVend) || (state_d == kSReturn);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= kSIdle;
         bal_q     <= '0;
         timeset_q <= 1'b0;
         avail_q   <= '0;
         item_q    <= '0;
         ret_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bal_q     <= bal_d;
         timeset_q <= timeset_d;
         avail_q   <= avail_d;
         item_q    <= item_d;
         ret_q     <= ret_d;
         busy_q    <= busy_d;
      end
   end

   assign o_timeset        = timeset_q;
   assign o_available_item = avail_q;
   assign o_output_item    = item_q;
   assign o_return_coin    = ret_q;
   assign o_balance        = bal_q;
   assign o_busy           = busy_q;

endmodule

// File: tb/tb_vending_txn_ctrl.sv
// Directed bench for vending_txn_ctrl with a queue of expected output snapshots.
module tb_vending_txn_ctrl;

   logic        clk;
   logic        reset_n;
   logic [2:0]  i_input_coin;
   logic [3:0]  i_select_item;
   logic        i_timeout;
   logic        i_trigger_return;
   logic        o_timeset;
   logic [3:0]  o_available_item;
   logic [3:0]  o_output_item;
   logic [2:0]  o_return_coin;
   logic [30:0] o_balance;
   logic        o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       tag;
      logic        ts;
      logic [3:0]  avail;
      logic [3:0]  item;
      logic [2:0]  ret;
      logic [30:0] bal;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];

   vending_txn_ctrl dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_timeout        (i_timeout),
`ifdef VM_TXN_CANCEL_EN
      .i_trigger_return (i_trigger_return),
`endif
      .o_timeset        (o_timeset),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_balance        (o_balance),
      .o_busy           (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] av(input logic [30:0] b);
      return {b >= 31'd2000, b >= 31'd1000, b >= 31'd500, b >= 31'd400};
   endfunction

   task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic ts, input logic [3:0] avail,
                             input logic [3:0] item, input logic [2:0] ret,
                             input logic [30:0] bal, input logic busy);
      exp_t e;
      e.tag = tag; e.ts = ts; e.avail = avail; e.item = item;
      e.ret = ret; e.bal = bal; e.busy = busy;
      exp_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         e = exp_q.pop_front();
         chk(e.tag, "timeset", 32'(o_timeset),        32'(e.ts));
         chk(e.tag, "avail",   32'(o_available_item), 32'(e.avail));
         chk(e.tag, "item",    32'(o_output_item),    32'(e.item));
         chk(e.tag, "ret",     32'(o_return_coin),    32'(e.ret));
         chk(e.tag, "bal",     32'(o_balance),        32'(e.bal));
         chk(e.tag, "busy",    32'(o_busy),           32'(e.busy));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_now();
      i_input_coin  = '0;
      i_select_item = '0;
   endtask

   initial begin
      reset_n          = 1'b0;
      i_input_coin     = '0;
      i_select_item    = '0;
      i_timeout        = 1'b0;
      i_trigger_return = 1'b0;
      #2;
      expect_out("reset", 0, 4'b0000, 0, 0, 0, 0);
      check_now();
      @(negedge clk);
      reset_n = 1'b1;

      // coins 500 then 1000
      i_input_coin = 3'b010; expect_out("coin500", 1, 4'b0011, 0, 0, 500, 0);   step();
      i_input_coin = 3'b100; expect_out("coin1000", 1, 4'b0111, 0, 0, 1500, 0); step();

      // buy item1, pulse lasts one cycle
      i_select_item = 4'b0010; expect_out("vend1", 1, 4'b0111, 4'b0010, 0, 1000, 1); step();
      expect_out("vend1_after", 0, 4'b0111, 0, 0, 1000, 0); step();

      // unaffordable selection at 1500
      i_input_coin = 3'b010; expect_out("to1500", 1, 4'b0111, 0, 0, 1500, 0); step();
      i_select_item = 4'b1000; expect_out("no_afford", 0, 4'b0111, 0, 0, 1500, 0); step();

      // 1600 then timeout; first timeout cycle masked by the pending reload
      i_input_coin = 3'b001; expect_out("to1600", 1, 4'b0111, 0, 0, 1600, 0); step();
      i_timeout = 1'b1; expect_out("to_masked", 0, 4'b0111, 0, 0, 1600, 0); step();
      expect_out("to_return", 0, 4'b0000, 0, 0, 1600, 1); step();
      i_timeout = 1'b0;
      expect_out("chg1000", 0, 4'b0000, 0, 3'b100, 600, 1); step();
      expect_out("chg500",  0, 4'b0000, 0, 3'b010, 100, 1); step();
      expect_out("chg100",  0, 4'b0000, 0, 3'b001, 0, 0);   step();
      expect_out("idle",    0, 4'b0000, 0, 0, 0, 0);        step();

      // multi-hot coin ignored
      i_input_coin = 3'b011; expect_out("multicoin", 0, 4'b0000, 0, 0, 0, 0); step();

      // fill to 9500, then bounce a 1000
      for (int k = 1; k <= 9; k++) begin
         i_input_coin = 3'b100;
         expect_out("fill", 1, av(31'(k * 1000)), 0, 0, 31'(k * 1000), 0);
         step();
      end
      i_input_coin = 3'b010; expect_out("to9500", 1, 4'b1111, 0, 0, 9500, 0); step();
      i_input_coin = 3'b100; expect_out("bounce", 0, 4'b1111, 0, 3'b100, 9500, 0); step();

      // coin and select together: coin wins, reaching the ceiling exactly
      i_input_coin = 3'b010; i_select_item = 4'b0001;
      expect_out("coin_over_sel", 1, 4'b1111, 0, 0, 10000, 0); step();
      i_select_item = 4'b0011; expect_out("multisel", 0, 4'b1111, 0, 0, 10000, 0); step();
      i_select_item = 4'b1000; expect_out("vend3", 1, 4'b1111, 4'b1000, 0, 8000, 1); step();
      expect_out("vend3_after", 0, 4'b1111, 0, 0, 8000, 0); step();

      // reset in the middle of RETURN
      i_timeout = 1'b1; expect_out("ret8000", 0, 4'b0000, 0, 0, 8000, 1); step();
      i_timeout = 1'b0;
      expect_out("ret8000_c1", 0, 4'b0000, 0, 3'b100, 7000, 1); step();
      #2;
      reset_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 4'b0000, 0, 0, 0, 0);
      check_now();
      @(negedge clk);
      reset_n = 1'b1;
      expect_out("post_rst", 0, 4'b0000, 0, 0, 0, 0); step();

`ifdef VM_TXN_CANCEL_EN
      i_input_coin = 3'b010; expect_out("c500", 1, 4'b0011, 0, 0, 500, 0); step();
      i_input_coin = 3'b001; expect_out("c600", 1, 4'b0011, 0, 0, 600, 0); step();
      i_input_coin = 3'b001; expect_out("c700", 1, 4'b0011, 0, 0, 700, 0); step();
      i_trigger_return = 1'b1; expect_out("cancel", 0, 4'b0000, 0, 0, 700, 1); step();
      i_trigger_return = 1'b0;
      expect_out("cchg500", 0, 4'b0000, 0, 3'b010, 200, 1); step();
      expect_out("cchg100a", 0, 4'b0000, 0, 3'b001, 100, 1); step();
      expect_out("cchg100b", 0, 4'b0000, 0, 3'b001, 0, 0); step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
